// File: rtl/clock_pkg.sv
// clock_pkg: shared widths, limits and alarm state encoding for the alarm block
package clock_pkg;
    localparam int MAX_HOURS   = 24;
    localparam int MAX_MINUTES = 60;
    localparam int HOURS_W     = $clog2(MAX_HOURS) + 1;
    localparam int MINUTES_W   = $clog2(MAX_MINUTES) + 1;
    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} alarm_state_t;
endpackage

// File: rtl/alarm_snooze_timer.sv
// alarm_snooze_timer: counts snooze seconds/minutes while running and flags expiry
//   clk, rst (sync active-low), run_i (count while high, clear while low),
//   sec_tick_i (1 Hz strobe), expire_o (snooze length reached)
module alarm_snooze_timer
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic sec_tick_i,
    output logic expire_o
);
    logic [5:0] sec_q;
    logic [5:0] min_q;
    logic       done;

    // Counting stops once the snooze length is reached, so the counters hold
    // instead of wrapping into a second, false expiry.
    assign done     = min_q == 6'(SNOOZE_MIN);
    assign expire_o = run_i && done;

    always_ff @(posedge clk) begin
        if (!rst || !run_i) begin
            sec_q <= '0;
            min_q <= '0;
        end else if (sec_tick_i && !done) begin
            sec_q <= (sec_q == 6'(MAX_MINUTES - 1)) ? '0 : sec_q + 6'd1;
            min_q <= (sec_q == 6'(MAX_MINUTES - 1)) ? min_q + 6'd1 : min_q;
        end
    end
endmodule

// File: rtl/alarm_unit.sv
// alarm_unit: stores the alarm time, compares it with the running clock and rings
//   clk, rst (sync active-low); set_alarm/set_hours/set_minutes (set strobe + payload);
//   cur_hours/cur_minutes (running time); sec_tick (1 Hz); alarm_en (arm level);
//   stop_btn/snooze_btn (pulses); alarm_hours/alarm_minutes/alarm_valid (stored time);
//   alarm_ring, snoozed (event state); set_err (rejected-set pulse)
module alarm_unit
    import clock_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_MIN     = 5,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_alarm,
    input  logic [MINUTES_W-1:0] set_minutes,
    input  logic [HOURS_W-1:0]   set_hours,
    input  logic [HOURS_W-1:0]   cur_hours,
    input  logic [MINUTES_W-1:0] cur_minutes,
    input  logic                 sec_tick,
    input  logic                 alarm_en,
    input  logic                 stop_btn,
    input  logic                 snooze_btn,
    output logic [HOURS_W-1:0]   alarm_hours,
    output logic [MINUTES_W-1:0] alarm_minutes,
    output logic                 alarm_valid,
    output logic                 alarm_ring,
    output logic                 snoozed,
    output logic                 set_err
);
    alarm_state_t         state_q;
    logic [HOURS_W-1:0]   hours_q;
    logic [MINUTES_W-1:0] minutes_q;
    logic                 valid_q;
    logic                 match_q;
    logic                 set_err_q;
    logic [7:0]           ring_cnt_q;
    logic [7:0]           snz_cnt_q;
    logic                 set_ok;
    logic                 match;
    logic                 trigger;
    logic                 snz_expire;

    assign set_ok  = set_alarm && set_hours < HOURS_W'(MAX_HOURS) && set_minutes < MINUTES_W'(MAX_MINUTES);
    assign match   = valid_q && cur_hours == hours_q && cur_minutes == minutes_q;
    // Edge of the match: a stop inside the matching minute cannot retrigger.
    assign trigger = match && !match_q;

    alarm_snooze_timer #(.SNOOZE_MIN(SNOOZE_MIN)) u_snooze (
        .clk        (clk),
        .rst        (rst),
        .run_i      (state_q == SNOOZE),
        .sec_tick_i (sec_tick),
        .expire_o   (snz_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            hours_q    <= '0;
            minutes_q  <= '0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            set_err_q  <= 1'b0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
        end else begin
            match_q   <= match;
            set_err_q <= set_alarm && !set_ok;
            if (set_ok) begin
                hours_q    <= set_hours;
                minutes_q  <= set_minutes;
                valid_q    <= 1'b1;
                state_q    <= alarm_en ? ARMED : IDLE;
                ring_cnt_q <= '0;
                snz_cnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: if (alarm_en && valid_q) state_q <= ARMED;
                    ARMED: begin
                        if (!alarm_en) state_q <= IDLE;
                        else if (trigger) begin
                            state_q    <= RINGING;
                            ring_cnt_q <= '0;
                            snz_cnt_q  <= '0;
                        end
                    end
                    RINGING: begin
                        if (!alarm_en) state_q <= IDLE;
                        else if (stop_btn) state_q <= ARMED;
                        else if (snooze_btn) begin
                            // Once the snooze allowance is used up, snooze acts as stop.
                            state_q   <= (snz_cnt_q < 8'(MAX_SNOOZES)) ? SNOOZE : ARMED;
                            snz_cnt_q <= (snz_cnt_q < 8'(MAX_SNOOZES)) ? snz_cnt_q + 8'd1 : snz_cnt_q;
                        end else if (sec_tick) begin
                            state_q    <= (ring_cnt_q >= 8'(RING_TIMEOUT_S - 1)) ? ARMED : RINGING;
                            ring_cnt_q <= (ring_cnt_q >= 8'(RING_TIMEOUT_S - 1)) ? ring_cnt_q : ring_cnt_q + 8'd1;
                        end
                    end
                    SNOOZE: begin
                        if (!alarm_en) state_q <= IDLE;
                        else if (stop_btn) state_q <= ARMED;
                        else if (snz_expire) begin
                            state_q    <= RINGING;
                            ring_cnt_q <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign alarm_hours   = hours_q;
    assign alarm_minutes = minutes_q;
    assign alarm_valid   = valid_q;
    assign alarm_ring    = state_q == RINGING;
    assign snoozed       = state_q == SNOOZE;
    assign set_err       = set_err_q;
endmodule

// File: doc/alarm_unit.md
Name: alarm_unit

Overview:
Receiving end of the alarm-setting interface. It captures the one-cycle set_alarm strobe with its set_hours/set_minutes payload and holds the alarm time. It compares the stored time against the running clock time and drives the alarm ring output. It handles stop, snooze and ring timeout, and sits between the settings block and the clock/indicator logic.

Parameters:
RING_TIMEOUT_S, 60, seconds of continuous ringing before automatic silence (1..255)
SNOOZE_MIN, 5, snooze length in minutes (1..59)
MAX_SNOOZES, 3, snoozes allowed per alarm event; the next snooze press acts as stop

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset (sampled on posedge clk only)
set_alarm  input  1  one-cycle strobe; payload valid in the same cycle
set_minutes  input  7  alarm minutes, [$clog2(60):0]
set_hours  input  6  alarm hours, [$clog2(24):0]
cur_hours  input  6  running time hours
cur_minutes  input  7  running time minutes
sec_tick  input  1  one-cycle 1 Hz strobe from the timebase
alarm_en  input  1  level; 0 disarms the alarm
stop_btn  input  1  debounced one-cycle pulse
snooze_btn  input  1  debounced one-cycle pulse
alarm_hours  output  6  stored alarm hours
alarm_minutes  output  7  stored alarm minutes
alarm_valid  output  1  a legal alarm time is stored
alarm_ring  output  1  ringing
snoozed  output  1  in snooze interval
set_err  output  1  one-cycle pulse when a set is rejected

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, alarm_hours=0, alarm_minutes=0, alarm_valid=0, alarm_ring=0, snoozed=0, set_err=0, all counters=0, match_q=0. Reset overrides every other input, including in RINGING or SNOOZE.
- Set capture: on set_alarm=1 with set_hours<24 and set_minutes<60, the values are registered next cycle and alarm_valid=1.
  - Out-of-range payload: stored time is unchanged; set_err=1 for exactly one cycle.
  - A valid set in RINGING or SNOOZE cancels the event: state→ARMED if alarm_en else IDLE, ring/snooze cleared, snooze count=0.
- match = alarm_valid && cur_hours==alarm_hours && cur_minutes==alarm_minutes. match_q is match registered each cycle. trigger = match && !match_q, so there is one trigger per minute entry.
- FSM:
  - IDLE: go to ARMED when alarm_en && alarm_valid.
  - ARMED: alarm_en=0 → IDLE. trigger → RINGING, with ring_cnt=0 and snooze count=0.
  - RINGING: alarm_ring=1 combinationally from the state; output is high the cycle after trigger.
    - stop_btn → ARMED.
    - snooze_btn with snooze count<MAX_SNOOZES → SNOOZE, snooze count+1, sec_cnt=0, min_cnt=0.
    - snooze_btn with snooze count==MAX_SNOOZES → ARMED (treated as stop).
    - ring_cnt increments on sec_tick; reaching RING_TIMEOUT_S → ARMED.
    - alarm_en=0 → IDLE.
  - SNOOZE: snoozed=1. sec_cnt counts sec_tick 0..59 and wraps, incrementing min_cnt. min_cnt==SNOOZE_MIN → RINGING with ring_cnt=0. stop_btn or alarm_en=0 → ARMED or IDLE respectively.
- Same-cycle priority, highest first: reset, valid set_alarm, alarm_en=0, stop_btn, snooze_btn, timeout/counter expiry, trigger.
- Stop within the matching minute does not retrigger, because match_q stays 1. The next trigger is the next day's entry into that minute.
- Snooze expiry is independent of match; it works across hour and midnight wrap.
- Counters saturate and never wrap into false expiry; ring_cnt is 8 bits, sec_cnt 6 bits, min_cnt 6 bits.

Decomposition:
- clock_pkg:
  - HOURS_W=$clog2(24)+1 and MINUTES_W=$clog2(60)+1 width constants.
  - MAX_HOURS=24 and MAX_MINUTES=60.
  - alarm_state_t enum {IDLE, ARMED, RINGING, SNOOZE}.
- One natural sub-module: alarm_snooze_timer (sec/min counter with start, clear and expire outputs), instantiated once.

Test Plan:
- Reset then set_alarm pulse with hours=2, minutes=40 → next cycle alarm_hours=2, alarm_minutes=40, alarm_valid=1. With alarm_en=1 the state reaches ARMED.
- set_alarm with hours=24, minutes=10 (or minutes=60) → set_err high for 1 cycle; stored 2:40 unchanged.
- Armed at 2:40, cur time steps 2:39→2:40 → alarm_ring=1 the following cycle. With no buttons, ring drops after exactly 60 sec_ticks. Held at 2:40, it does not retrigger.
- Ringing, snooze_btn → ring=0, snoozed=1. After 300 sec_ticks ring=1 again. A 4th snooze press (MAX_SNOOZES=3 used) → ring=0, state ARMED, snoozed=0.
- Ringing, stop_btn and snooze_btn in the same cycle → stop wins: ARMED, snoozed=0. A new set 3:15 during SNOOZE → snooze cancelled, alarm_minutes=15.
- rst=0 asserted mid-RINGING for one posedge → all outputs 0 next cycle, including alarm_valid. Pulsing rst=0 between clock edges has no effect (synchronous reset check).
